// File: rtl/sonic_port_ctrl.sv
// Bring-up and supervision FSM for one SONIC PHY port (XGMII clock domain).
// Define SONIC_PORT_CTRL_LPBK_TEST_EN to compile in the endec loopback self-test stage.
module sonic_port_ctrl #(
    parameter int unsigned LOCK_STABLE = 64,
    parameter int unsigned BACKOFF     = 1024,
    parameter int unsigned FCNT_W      = 8
) (
    input  logic              xgmii_clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              xcvr_tx_ready,
    input  logic              xcvr_rx_ready,
    input  logic              lock,
    input  logic [31:0]       init_timeout,
    input  logic [31:0]       sync_timeout,
    output logic              endec_loopback,
    output logic              clksync_disable,
    output logic              clear,
    output logic              port_up,
    output logic [2:0]        state_o,
    output logic              fault,
    output logic [FCNT_W-1:0] fault_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_XCVR = 3'd1;
    localparam logic [2:0] S_LPBK      = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_BACKOFF   = 3'd6;

    localparam logic [31:0] C_LOCK_STABLE = 32'(LOCK_STABLE);
    localparam logic [31:0] C_BACKOFF     = 32'(BACKOFF);

    logic [2:0]        r_state;
    logic [31:0]       r_timer;
    logic [31:0]       r_stable;
    logic [31:0]       r_low;
    logic              r_endec_loopback;
    logic              r_clksync_disable;
    logic              r_clear;
    logic              r_port_up;
    logic              r_fault;
    logic [FCNT_W-1:0] r_fault_cnt;

    logic [2:0]        w_state_next;
    logic [31:0]       w_timer_inc;
    logic [31:0]       w_stable_inc;
    logic [31:0]       w_low_inc;
    logic [31:0]       w_sync_limit;
    logic              w_ready;
    logic              w_qualified;
    logic              w_timeout;
    logic              w_sync_lost;
    logic              w_backoff_done;
    logic              w_entering;
    logic              w_fault_entry;

    // Counters show the value including the current cycle, so an entry cycle counts as 1.
    always_comb begin
        w_ready        = xcvr_tx_ready & xcvr_rx_ready;
        w_timer_inc    = (r_timer == 32'hFFFF_FFFF) ? r_timer : r_timer + 32'd1;
        w_stable_inc   = !lock ? 32'd0 :
                         ((r_stable == 32'hFFFF_FFFF) ? r_stable : r_stable + 32'd1);
        w_low_inc      = lock ? 32'd0 :
                         ((r_low == 32'hFFFF_FFFF) ? r_low : r_low + 32'd1);
        w_sync_limit   = (sync_timeout == 32'd0) ? 32'd1 : sync_timeout;
        w_qualified    = (w_stable_inc >= C_LOCK_STABLE);
        w_timeout      = (init_timeout != 32'd0) && (w_timer_inc >= init_timeout);
        w_sync_lost    = (w_low_inc >= w_sync_limit);
        w_backoff_done = (w_timer_inc >= C_BACKOFF);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_next = S_WAIT_XCVR;
            end
            S_WAIT_XCVR: begin
`ifdef SONIC_PORT_CTRL_LPBK_TEST_EN
                if (w_ready) w_state_next = S_LPBK;
`else
                if (w_ready) w_state_next = S_WAIT_LOCK;
`endif
            end
`ifdef SONIC_PORT_CTRL_LPBK_TEST_EN
            S_LPBK: begin
                if (!w_ready)         w_state_next = S_BACKOFF;
                else if (w_qualified) w_state_next = S_WAIT_LOCK;
                else if (w_timeout)   w_state_next = S_BACKOFF;
            end
`else
            S_LPBK: w_state_next = S_IDLE;
`endif
            S_WAIT_LOCK: begin
                if (!w_ready)         w_state_next = S_BACKOFF;
                else if (w_qualified) w_state_next = S_CLEAR;
                else if (w_timeout)   w_state_next = S_BACKOFF;
            end
            S_CLEAR: begin
                w_state_next = w_ready ? S_RUN : S_BACKOFF;
            end
            S_RUN: begin
                if (!w_ready || w_sync_lost) w_state_next = S_BACKOFF;
            end
            S_BACKOFF: begin
                if (w_backoff_done) w_state_next = S_WAIT_XCVR;
            end
            default: w_state_next = S_IDLE;
        endcase
        // Administrative disable overrides everything and is never reported as a fault.
        if (!enable) w_state_next = S_IDLE;
    end

    assign w_entering    = (w_state_next != r_state);
    assign w_fault_entry = (w_state_next == S_BACKOFF) && (r_state != S_BACKOFF);

    always_ff @(posedge xgmii_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_timer           <= 32'd0;
            r_stable          <= 32'd0;
            r_low             <= 32'd0;
            r_endec_loopback  <= 1'b0;
            r_clksync_disable <= 1'b1;
            r_clear           <= 1'b0;
            r_port_up         <= 1'b0;
            r_fault           <= 1'b0;
            r_fault_cnt       <= '0;
        end else begin
            r_state           <= w_state_next;
            r_timer           <= w_entering ? 32'd0 : w_timer_inc;
            r_stable          <= w_entering ? 32'd0 : w_stable_inc;
            r_low             <= w_entering ? 32'd0 : w_low_inc;
`ifdef SONIC_PORT_CTRL_LPBK_TEST_EN
            r_endec_loopback  <= (w_state_next == S_LPBK);
`else
            r_endec_loopback  <= 1'b0;
`endif
            r_clksync_disable <= (w_state_next != S_RUN);
            r_clear           <= (w_state_next == S_CLEAR);
            r_port_up         <= (w_state_next == S_RUN);
            r_fault           <= w_fault_entry;
            if (w_fault_entry && (r_fault_cnt != {FCNT_W{1'b1}})) begin
                r_fault_cnt <= r_fault_cnt + FCNT_W'(1);
            end
        end
    end

    assign state_o         = r_state;
    assign endec_loopback  = r_endec_loopback;
    assign clksync_disable = r_clksync_disable;
    assign clear           = r_clear;
    assign port_up         = r_port_up;
    assign fault           = r_fault;
    assign fault_cnt       = r_fault_cnt;

endmodule

// File: tb/tb_sonic_port_ctrl.sv
// Directed table-driven bench for sonic_port_ctrl, plus saturation and async-reset sequences.
// Expectations follow the build: SONIC_PORT_CTRL_LPBK_TEST_EN selects the loopback stage.
module tb_sonic_port_ctrl;

    localparam int LS = 64;
    localparam int BO = 32;
`ifdef SONIC_PORT_CTRL_LPBK_TEST_EN
    localparam int         LP    = 64;
    localparam logic [2:0] FIRST = 3'd2;
`else
    localparam int         LP    = 0;
    localparam logic [2:0] FIRST = 3'd3;
`endif
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WX = 3'd1, ST_WL = 3'd3,
                           ST_CLR = 3'd4, ST_RUN = 3'd5, ST_BO = 3'd6;

    logic        xgmii_clock = 1'b0;
    logic        reset_n     = 1'b0;
    logic        enable      = 1'b0;
    logic        xcvr_tx_ready = 1'b0;
    logic        xcvr_rx_ready = 1'b0;
    logic        lock        = 1'b0;
    logic [31:0] init_timeout = 32'd0;
    logic [31:0] sync_timeout = 32'd0;
    logic        endec_loopback, clksync_disable, clear, port_up, fault;
    logic [2:0]  state_o;
    logic [7:0]  fault_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en, tx, rx, lk;
        logic [31:0] ito, sto;
        int          cyc;
        logic [2:0]  st;
        logic        flt;
        logic [7:0]  cnt;
    } vec_t;
    vec_t tbl[$];

    sonic_port_ctrl #(.LOCK_STABLE(LS), .BACKOFF(BO), .FCNT_W(8)) dut (
        .xgmii_clock(xgmii_clock), .reset_n(reset_n), .enable(enable),
        .xcvr_tx_ready(xcvr_tx_ready), .xcvr_rx_ready(xcvr_rx_ready), .lock(lock),
        .init_timeout(init_timeout), .sync_timeout(sync_timeout),
        .endec_loopback(endec_loopback), .clksync_disable(clksync_disable),
        .clear(clear), .port_up(port_up), .state_o(state_o),
        .fault(fault), .fault_cnt(fault_cnt)
    );

    always #5 xgmii_clock = ~xgmii_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Output expectations derived from the expected state.
    task automatic chk_outs(input string tag, input logic [2:0] st, input logic flt,
                            input logic [7:0] cnt);
        chk({tag, "_state"},   32'(state_o),         32'(st));
        chk({tag, "_lpbk"},    32'(endec_loopback),  32'(st == 3'd2));
        chk({tag, "_csdis"},   32'(clksync_disable), 32'(st != ST_RUN));
        chk({tag, "_clear"},   32'(clear),           32'(st == ST_CLR));
        chk({tag, "_portup"},  32'(port_up),         32'(st == ST_RUN));
        chk({tag, "_fault"},   32'(fault),           32'(flt));
        chk({tag, "_fcnt"},    32'(fault_cnt),       32'(cnt));
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge xgmii_clock);
            #1;
        end
    endtask

    task automatic add(input logic en, input logic tx, input logic rx, input logic lk,
                       input int ito, input int sto, input int cyc,
                       input logic [2:0] st, input logic flt, input int cnt);
        vec_t v;
        v.en = en; v.tx = tx; v.rx = rx; v.lk = lk;
        v.ito = 32'(ito); v.sto = 32'(sto); v.cyc = cyc;
        v.st = st; v.flt = flt; v.cnt = 8'(cnt);
        tbl.push_back(v);
    endtask

    initial begin
        int exp_cnt;
        //  en tx rx lk  ito  sto  cycles        state   flt cnt
        // nominal bring-up
        add(1, 1, 1, 1,   0, 10, 1,            ST_WX,  0, 0);
        add(1, 1, 1, 1,   0, 10, 1,            FIRST,  0, 0);
        add(1, 1, 1, 1,   0, 10, LP + LS - 1,  ST_WL,  0, 0);
        add(1, 1, 1, 1,   0, 10, 1,            ST_CLR, 0, 0);
        add(1, 1, 1, 1,   0, 10, 1,            ST_RUN, 0, 0);
        // lock glitch shorter than sync_timeout, then a full-length loss
        add(1, 1, 1, 0,   0, 10, 9,            ST_RUN, 0, 0);
        add(1, 1, 1, 1,   0, 10, 5,            ST_RUN, 0, 0);
        add(1, 1, 1, 0,   0, 10, 9,            ST_RUN, 0, 0);
        add(1, 1, 1, 0,   0, 10, 1,            ST_BO,  1, 1);
        add(1, 1, 1, 0,   0, 10, 1,            ST_BO,  0, 1);
        add(1, 1, 1, 1,   0, 10, BO - 2,       ST_BO,  0, 1);
        add(1, 1, 1, 1,   0, 10, 1,            ST_WX,  0, 1);
        add(1, 1, 1, 1,   0, 10, 1,            FIRST,  0, 1);
        add(1, 1, 1, 1,   0, 10, LP + LS - 1,  ST_WL,  0, 1);
        add(1, 1, 1, 1,   0, 10, 1,            ST_CLR, 0, 1);
        add(1, 1, 1, 1,   0, 10, 1,            ST_RUN, 0, 1);
        // ready drop in RUN; ready is ignored during BACKOFF
        add(1, 1, 0, 1,   0, 10, 1,            ST_BO,  1, 2);
        add(1, 1, 0, 1,   0, 10, 1,            ST_BO,  0, 2);
        add(1, 1, 1, 1,   0, 10, BO - 2,       ST_BO,  0, 2);
        add(1, 1, 1, 1,   0, 10, 1,            ST_WX,  0, 2);
        // lock-acquisition timeout of 100 cycles
        add(1, 1, 1, 0, 100, 10, 1,            FIRST,  0, 2);
        add(1, 1, 1, 0, 100, 10, 99,           FIRST,  0, 2);
        add(1, 1, 1, 0, 100, 10, 1,            ST_BO,  1, 3);
        add(1, 1, 1, 0, 100, 10, BO - 1,       ST_BO,  0, 3);
        add(1, 1, 1, 0, 100, 10, 1,            ST_WX,  0, 3);
        // qualification and timeout on the same cycle
        add(1, 1, 1, 1,  64, 10, 1,            FIRST,  0, 3);
        add(1, 1, 1, 1,  64, 10, LP + LS - 1,  ST_WL,  0, 3);
        add(1, 1, 1, 1,  64, 10, 1,            ST_CLR, 0, 3);
        add(1, 1, 1, 1,  64, 10, 1,            ST_RUN, 0, 3);
        // enable drop, then infinite wait with init_timeout 0, then drop in WAIT_LOCK
        add(0, 1, 1, 1,   0, 10, 1,            ST_IDLE,0, 3);
        add(1, 1, 1, 0,   0, 10, 2,            FIRST,  0, 3);
        add(1, 1, 1, 0,   0, 10, 300,          FIRST,  0, 3);
        add(1, 1, 1, 1,   0, 10, LP,           ST_WL,  0, 3);
        add(1, 1, 1, 0,   0, 10, 5,            ST_WL,  0, 3);
        add(0, 1, 1, 0,   0, 10, 1,            ST_IDLE,0, 3);
        // ready drop on the qualifying cycle wins over qualification
        add(1, 1, 1, 1,   0,  0, 2,            FIRST,  0, 3);
        add(1, 1, 1, 1,   0,  0, LP + LS - 1,  ST_WL,  0, 3);
        add(1, 0, 1, 1,   0,  0, 1,            ST_BO,  1, 4);
        add(1, 1, 1, 1,   0,  0, BO - 1,       ST_BO,  0, 4);
        add(1, 1, 1, 1,   0,  0, 1,            ST_WX,  0, 4);

        // reset state
        tick(3);
        chk_outs("reset", ST_IDLE, 1'b0, 8'd0);
        reset_n = 1'b1;
        tick(2);
        chk_outs("idle", ST_IDLE, 1'b0, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            enable        = tbl[i].en;
            xcvr_tx_ready = tbl[i].tx;
            xcvr_rx_ready = tbl[i].rx;
            lock          = tbl[i].lk;
            init_timeout  = tbl[i].ito;
            sync_timeout  = tbl[i].sto;
            tick(tbl[i].cyc);
            chk_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].flt, tbl[i].cnt);
            $display("row %0d: state=%0d fault=%0d fault_cnt=%0d", i, state_o, fault, fault_cnt);
        end

        // fault counter saturation: 300 forced timeouts of one cycle
        init_timeout = 32'd1;
        lock         = 1'b0;
        exp_cnt      = 4;
        for (int k = 0; k < 300; k++) begin
            tick(2);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk($sformatf("sat%0d_fault", k), 32'(fault), 32'd1);
            chk($sformatf("sat%0d_fcnt", k), 32'(fault_cnt), 32'(exp_cnt));
            if (k < 299) tick(BO);
        end
        $display("saturation: fault_cnt=%0d", fault_cnt);

        // asynchronous reset in the middle of BACKOFF, checked before any clock edge
        tick(3);
        chk("pre_reset_state", 32'(state_o), 32'(ST_BO));
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs("async_reset", ST_IDLE, 1'b0, 8'd0);
        $display("async reset: state=%0d fault_cnt=%0d", state_o, fault_cnt);
        tick(2);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(1);
        chk_outs("post_reset", ST_WX, 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the directed run is far shorter than this.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sonic_port_ctrl.md
# sonic_port_ctrl

Bring-up and supervision controller for one SONIC PHY port, clocked in the XGMII domain. It sequences the port from reset to running clock synchronisation:
- waits for transceiver readiness;
- optionally self-tests the encoder→decoder path through endec loopback;
- qualifies decoder block lock and clears the local counters;
- releases the clock-sync state machine.

It drives the port's `endec_loopback`, `clksync_disable` and `clear` controls. On lock loss it backs off and retries.

## Interface
Parameters:
- `LOCK_STABLE`, 64 — consecutive `lock`-high cycles required to qualify lock.
- `BACKOFF`, 1024 — cycles spent in BACKOFF before a retry.
- `FCNT_W`, 8 — width of the fault counter.

Ports:
- `xgmii_clock`  in  1  — sole clock.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — administrative enable; 0 forces IDLE.
- `xcvr_tx_ready`  in  1  — TX transceiver ready, synchronous to `xgmii_clock`.
- `xcvr_rx_ready`  in  1  — RX transceiver ready, synchronous to `xgmii_clock`.
- `lock`  in  1  — decoder block-sync lock.
- `init_timeout`  in  32  — lock-acquisition bound in cycles; 0 means no timeout.
- `sync_timeout`  in  32  — tolerated consecutive `lock`-low cycles in RUN; 0 is treated as 1.
- `endec_loopback`  out  1  — encoder→decoder loopback select.
- `clksync_disable`  out  1  — holds clocksync in reset.
- `clear`  out  1  — one-cycle clear of the local counters.
- `port_up`  out  1  — port running.
- `state_o`  out  3  — current state encoding.
- `fault`  out  1  — one-cycle pulse on entry to BACKOFF.
- `fault_cnt`  out  `FCNT_W`  — saturating count of BACKOFF entries.

## Operation
State encodings:
- IDLE = 0, WAIT_XCVR = 1, LPBK = 2, WAIT_LOCK = 3, CLEAR = 4, RUN = 5, BACKOFF = 6.
- Code 7 is unreachable; it recovers to IDLE.

Global rule:
- `enable` = 0 in any state moves to IDLE next cycle. This has top priority.
- `fault` is not pulsed and `fault_cnt` is unchanged on an `enable` drop.

Transitions:
- IDLE: `enable` = 1 → WAIT_XCVR.
- WAIT_XCVR:
  - both ready inputs = 1 → LPBK when the macro is defined, otherwise WAIT_LOCK;
  - no timeout in this state.
- LPBK:
  - `endec_loopback` = 1;
  - lock qualified → WAIT_LOCK;
  - timeout → BACKOFF.
- WAIT_LOCK:
  - `endec_loopback` = 0;
  - lock qualified → CLEAR;
  - timeout → BACKOFF.
- CLEAR: `clear` = 1 for exactly one cycle → RUN.
- RUN:
  - `port_up` = 1 and `clksync_disable` = 0;
  - `lock` low for `sync_timeout` consecutive cycles → BACKOFF;
  - a shorter low run resets the low counter when `lock` returns high.
- Ready drop:
  - applies in LPBK, WAIT_LOCK, CLEAR and RUN;
  - either ready input = 0 → BACKOFF in the next cycle.
- BACKOFF:
  - stays exactly `BACKOFF` cycles → WAIT_XCVR;
  - `fault_cnt` increments on entry and saturates at all-ones.

Lock qualification:
- A stability counter resets on every state entry and whenever `lock` = 0.
- Lock qualifies when the counter reaches `LOCK_STABLE`.
- This applies only in LPBK and WAIT_LOCK.

Timeouts:
- The state timer is 32 bits, reset on entry; the entry cycle counts as cycle 1.
- If lock has not qualified by the end of cycle `init_timeout`, the next cycle is BACKOFF.
- Qualification and timeout in the same cycle: qualification wins.
- Ready-drop beats both qualification and timeout.

Output values by state:
- `clksync_disable` = 1 in every state except RUN.
- `endec_loopback` = 1 only in LPBK.
- `clear` = 1 only in CLEAR.
- `port_up` = 1 only in RUN.

## Timing
- All outputs are registered and reflect the current state. There is no combinational input→output path.
- Reset values:
  - state IDLE (`state_o` = 0);
  - `endec_loopback` = 0, `clksync_disable` = 1, `clear` = 0, `port_up` = 0;
  - `fault` = 0, `fault_cnt` = 0;
  - all internal counters 0.
- Asserting `reset_n` low mid-operation returns every output to its reset value immediately, asynchronously.
- Deassertion is synchronous to `xgmii_clock`, via an external synchroniser.
- Latencies:
  - input change → state change: 1 cycle;
  - `lock` rising in WAIT_LOCK (held high) → CLEAR: `LOCK_STABLE` cycles;
  - CLEAR → RUN: 1 cycle.
- `fault` is high during the first BACKOFF cycle only.

## Configuration
- Macro: `SONIC_PORT_CTRL_LPBK_TEST_EN`.
- Defined:
  - the LPBK self-test stage is compiled in;
  - a failed loopback test counts as a fault and retries through BACKOFF.
- Undefined:
  - the LPBK logic is removed;
  - WAIT_XCVR goes directly to WAIT_LOCK;
  - `endec_loopback` is tied to 0;
  - encoding 2 is unreachable and recovers to IDLE.

## Test plan
- Nominal bring-up. Setup: `LOCK_STABLE`=64, macro defined, `enable`=1, both ready inputs=1, `lock` held 1.
  - LPBK for 64 cycles, then WAIT_LOCK 64 cycles, then CLEAR 1 cycle, then RUN with `port_up`=1 and `clksync_disable`=0.
  - `clear` is high for exactly one cycle.
- Lock timeout. Setup: `init_timeout`=100, `lock`=0.
  - BACKOFF entered on cycle 101 of LPBK; `fault` pulses; `fault_cnt`=1.
  - After `BACKOFF`=1024 cycles, state returns to WAIT_XCVR.
- Lock glitch in RUN. Setup: `sync_timeout`=10.
  - `lock` low 9 cycles, then high → stays in RUN.
  - `lock` low 10 cycles → BACKOFF, and `clksync_disable` rises.
- Ready drop and reset. Setup: in RUN.
  - `xcvr_rx_ready`→0 → BACKOFF next cycle, `fault`=1.
  - `reset_n`→0 mid-BACKOFF → all outputs at reset values without waiting for a clock edge.
- Corner cases:
  - qualification and timeout on the same cycle (`init_timeout`=64, `lock` high from entry) → CLEAR path, no fault;
  - `init_timeout`=0 → waits indefinitely;
  - 300 forced faults → `fault_cnt` saturates at 255.
- Enable drop. Setup: `enable`→0 in WAIT_LOCK.
  - State is IDLE next cycle; `fault`=0; `fault_cnt` unchanged.
